// File: rtl/field_sink.sv
// Deinterlacer input stage: decodes the Avalon-ST control packet and writes
// successive video lines into a ping-pong pair of line buffers.
module field_sink #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HALF_HEIGHT = 240
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic                  wr_req0,
  output logic                  wr_req1,
  output logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] d1,
  input  logic                  full0,
  input  logic                  full1,
  output logic                  ready_to_continue,
  input  logic                  aver_sent,
  output logic [15:0]           ctrl_width,
  output logic [15:0]           ctrl_height,
  output logic                  frame_error
);

  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LW = (HALF_HEIGHT > 1) ? $clog2(HALF_HEIGHT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CTRL, S_WAIT, S_FILL, S_DONE, S_SKIP} state_t;

  state_t                state_q, state_d;
  logic                  target_q, target_d;
  logic [LW-1:0]         line_q, line_d;
  logic [PW-1:0]         pix_q, pix_d;
  logic [3:0]            cidx_q, cidx_d;
  logic [15:0]           cw_q, cw_d, ch_q, ch_d;
  logic                  fe_q, fe_d, rtc_q, rtc_d, aver_q;
  logic                  wr0_q, wr0_d, wr1_q, wr1_d;
  logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic                  ready_int, beat, full_tgt, full_nxt, aver_rise;

  assign full_tgt  = target_q ? full1 : full0;
  assign full_nxt  = target_q ? full0 : full1;
  assign aver_rise = aver_sent & ~aver_q;
  assign beat      = din_valid & ready_int;

  always_comb begin
    case (state_q)
      S_IDLE, S_CTRL, S_SKIP: ready_int = 1'b1;
      S_FILL:                 ready_int = ~full_tgt;
      default:                ready_int = 1'b0;
    endcase
  end

  // Gated by reset so every output reads 0 while reset is held.
  assign din_ready = ready_int & ~reset;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    line_d   = line_q;
    pix_d    = pix_q;
    cidx_d   = cidx_q;
    cw_d     = cw_q;
    ch_d     = ch_q;
    fe_d     = fe_q;
    rtc_d    = rtc_q;
    wr0_d    = 1'b0;
    wr1_d    = 1'b0;
    d0_d     = d0_q;
    d1_d     = d1_q;
    if (aver_rise) rtc_d = 1'b0;
    case (state_q)
      S_IDLE: if (beat && din_startofpacket) begin
        if (din_data[3:0] == 4'hF) begin
          if (din_endofpacket) fe_d = 1'b1;
          else begin state_d = S_CTRL; cidx_d = 4'd1; end
        end else if (din_data[3:0] == 4'h0) begin
          if (din_endofpacket) fe_d = 1'b1;
          else state_d = S_WAIT;
        end else if (!din_endofpacket) begin
          state_d = S_SKIP;
        end
      end
      S_CTRL: if (beat) begin
        if (cidx_q >= 4'd1 && cidx_q <= 4'd4) cw_d = {cw_q[11:0], din_data[3:0]};
        if (cidx_q >= 4'd5 && cidx_q <= 4'd8) ch_d = {ch_q[11:0], din_data[3:0]};
        cidx_d = cidx_q + 4'd1;
        if (din_endofpacket) begin
          state_d = S_IDLE;
          if (cidx_q != 4'd9 || cw_q != 16'(WIDTH) || ch_q != 16'(HALF_HEIGHT)) fe_d = 1'b1;
        end else if (cidx_q == 4'd9) begin
          fe_d    = 1'b1;
          state_d = S_SKIP;
        end
      end
      S_WAIT: if (!full_tgt) begin
        state_d = S_FILL;
        rtc_d   = 1'b0;
      end
      S_FILL: if (beat) begin
        if (target_q) begin wr1_d = 1'b1; d1_d = din_data; end
        else          begin wr0_d = 1'b1; d0_d = din_data; end
        if (pix_q == PW'(WIDTH - 1)) begin
          pix_d = '0;
          if (line_q == LW'(HALF_HEIGHT - 1)) begin
            line_d   = '0;
            target_d = 1'b0;
            if (din_endofpacket) begin state_d = S_DONE; rtc_d = 1'b1; end
            else begin state_d = S_SKIP; fe_d = 1'b1; rtc_d = 1'b0; end
          end else if (din_endofpacket) begin
            state_d = S_IDLE; fe_d = 1'b1; line_d = '0; target_d = 1'b0; rtc_d = 1'b0;
          end else begin
            state_d  = S_WAIT;
            line_d   = line_q + LW'(1);
            target_d = ~target_q;
            rtc_d    = full_nxt;
          end
        end else begin
          pix_d = pix_q + PW'(1);
          if (din_endofpacket) begin
            state_d = S_IDLE; fe_d = 1'b1; pix_d = '0; line_d = '0; target_d = 1'b0; rtc_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        rtc_d = 1'b1;
        if (aver_rise || (!full0 && !full1)) begin state_d = S_IDLE; rtc_d = 1'b0; end
      end
      S_SKIP: if (beat && din_endofpacket) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= 1'b0;
      line_q   <= '0;
      pix_q    <= '0;
      cidx_q   <= '0;
      cw_q     <= '0;
      ch_q     <= '0;
      fe_q     <= 1'b0;
      rtc_q    <= 1'b0;
      aver_q   <= 1'b0;
      wr0_q    <= 1'b0;
      wr1_q    <= 1'b0;
      d0_q     <= '0;
      d1_q     <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      line_q   <= line_d;
      pix_q    <= pix_d;
      cidx_q   <= cidx_d;
      cw_q     <= cw_d;
      ch_q     <= ch_d;
      fe_q     <= fe_d;
      rtc_q    <= rtc_d;
      aver_q   <= aver_sent;
      wr0_q    <= wr0_d;
      wr1_q    <= wr1_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
    end
  end

  assign wr_req0           = wr0_q;
  assign wr_req1           = wr1_q;
  assign d0                = d0_q;
  assign d1                = d1_q;
  assign ready_to_continue = rtc_q;
  assign ctrl_width        = cw_q;
  assign ctrl_height       = ch_q;
  assign frame_error       = fe_q;

endmodule

// File: doc/field_sink.md
# field_sink

Upstream input stage of the deinterlacer. It accepts an interlaced field as Avalon-ST video: a control packet, then a video packet of HALF_HEIGHT lines × WIDTH pixels. It writes successive lines alternately into line buffer 0 and line buffer 1 (ping-pong), which the output source stage reads. It also runs the line-level `ready_to_continue` / `aver_sent` handshake with that source stage.

## Interface
- DATA_WIDTH, 8, pixel/symbol width
- WIDTH, 640, pixels per line
- HALF_HEIGHT, 240, lines per field
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- din_data  in  DATA_WIDTH  Avalon-ST symbol
- din_valid  in  1  symbol valid
- din_ready  out  1  sink ready; a beat transfers when din_valid && din_ready
- din_startofpacket  in  1  first beat of packet
- din_endofpacket  in  1  last beat of packet
- wr_req0 / wr_req1  out  1  write strobe, line buffer 0 / 1
- d0 / d1  out  DATA_WIDTH  write data, line buffer 0 / 1
- full0 / full1  in  1  buffer holds WIDTH words; cleared by buffer when drained
- ready_to_continue  out  1  latest line is written and the next target buffer is still occupied
- aver_sent  in  1  source finished an interpolated line (level; rising edge is the event)
- ctrl_width / ctrl_height  out  16  fields decoded from last control packet
- frame_error  out  1  sticky protocol error flag

## Operation
- Reset values: all outputs 0; target buffer = 0; line and pixel counters = 0.
- States and transitions:
  - IDLE: din_ready=1. Beat with sop:
    - data[3:0]=0xF → CTRL, beat index 1.
    - data[3:0]=0x0 → VIDEO_WAIT_BUF.
    - other type → SKIP.
    - Beat without sop → dropped.
  - CTRL: din_ready=1.
    - Beats 1–4 load ctrl_width[15:0] nibbles, MSB first (data[3:0]).
    - Beats 5–8 load ctrl_height nibbles the same way.
    - Beat 9 is the interlace nibble, ignored.
    - eop → IDLE.
    - eop before beat 9, or no eop at beat 9 → frame_error=1, then SKIP (if no eop yet) or IDLE.
    - At packet end, ctrl_width≠WIDTH or ctrl_height≠HALF_HEIGHT → frame_error=1. Video is still processed with the parameter sizes.
  - VIDEO_WAIT_BUF: din_ready=0. Moves to FILL when the full flag of the target buffer is 0.
  - FILL: din_ready = ~full[target].
    - Each accepted beat: pixel counter +1, and a write to the target buffer one cycle later.
    - On pixel WIDTH-1: counter → 0, line +1, target toggles, state → VIDEO_WAIT_BUF.
    - Exception: if the last line of the field is done, state → FIELD_DONE.
  - FIELD_DONE: din_ready=0. Waits for the rising edge of aver_sent or full0=full1=0, then → IDLE, line=0, target=0.
  - SKIP: din_ready=1. Discards beats until eop, then → IDLE.
- eop handling in video:
  - eop must coincide with pixel WIDTH-1 of line HALF_HEIGHT-1.
  - Early eop → frame_error=1, → IDLE, counters cleared, target=0.
  - Missing eop after the last pixel → frame_error=1, → SKIP.
- ready_to_continue:
  - Set when a line completes and full of the new target is 1.
  - Cleared on the rising edge of aver_sent (detected against a registered copy), or when the new target's full drops.
  - Also held 1 in FIELD_DONE until exit.
- frame_error is cleared only by reset.

## Timing
- din_ready is combinational from state and full flags.
- A beat accepted in cycle N gives wr_reqX=1, dX=data in cycle N+1. Write latency is fixed at 1. Non-target wr_req is 0. dX holds its last value when idle.
- Back-to-back writes run at one pixel per clock while din_valid=1.
- Target toggles in the same cycle as the last-pixel accept, so the first pixel of the next line is never written to the previous buffer.
- full of the old target may rise 1–2 cycles after its last write; the sink does not sample it until it targets that buffer again.
- Simultaneous eop and full of the next target: end-of-line/field handling takes priority; VIDEO_WAIT_BUF then stalls.
- Reset mid-line: immediate return to IDLE, partial line abandoned, wr_req0/1 drop asynchronously.

## Test plan
- Nominal field, WIDTH=4, HALF_HEIGHT=3, control packet 0F,0,0,0,4,0,0,0,3,2, then video:
  - Line 0 pixels 1–4 → d0, line 1 → d1, line 2 → d0 after full0 drops.
  - ctrl_width=4, ctrl_height=3, frame_error=0.
- Backpressure: full1 held 1 after line 0:
  - din_ready=0 and ready_to_continue=1.
  - aver_sent rises → ready_to_continue=0.
  - full1 falls → line 1 is written, first wr_req1 one cycle after the first accept.
- Control mismatch: width nibbles give 5 → frame_error=1; video still writes 4 pixels per line.
- Early eop on line 1 pixel 2 → frame_error=1, IDLE, next field starts again in buffer 0.
- Unknown packet type 0x3 with 6 beats → all beats accepted, no writes, IDLE after eop.
- Reset asserted at line 1 pixel 2 → all outputs 0 in the same cycle; a fresh field afterwards writes from buffer 0, pixel 0.
